can_brs_ctrl: RTL and testbench

- Bit-rate-switch controller for the CAN FD receive path; sequences the bit-timing logic between nominal and data-phase timing.
- Holds shadow copies of the nominal and data timing registers. Selects which set drives the bit-timing logic, and switches at the protocol-defined sample points:
  - to data timing at the BRS sample point;
  - back to nominal at the CRC-delimiter sample point, or on any error or overload.
- Sits between the register file and the bit-timing logic; event inputs come from the bit-stream processor.

---
 rtl/can_brs_ctrl.sv | 157 +++++++++++++++
 tb/tb_can_brs_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/can_brs_ctrl.sv
// CAN FD bit-rate-switch controller: shadows nominal/data timing and selects the active set.
// Optional data-phase watchdog compiled in with `define CAN_BRS_WATCHDOG_EN.
module can_brs_ctrl #(
    parameter int              WDOG_W     = 10,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 10'd640
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reset_mode,
    input  logic       en_fd,
    input  logic [5:0] nom_brp,
    input  logic [1:0] nom_sjw,
    input  logic [3:0] nom_tseg1,
    input  logic [2:0] nom_tseg2,
    input  logic [5:0] dat_brp,
    input  logic [1:0] dat_sjw,
    input  logic [3:0] dat_tseg1,
    input  logic [2:0] dat_tseg2,
    input  logic       rx_idle,
    input  logic       sample_point,
    input  logic       go_rx_brs_on,
    input  logic       go_rx_crc_lim,
    input  logic       go_error_frame,
    input  logic       go_overload_frame,
    output logic [5:0] act_brp,
    output logic [1:0] act_sjw,
    output logic [3:0] act_tseg1,
    output logic [2:0] act_tseg2,
    output logic       data_phase,
    output logic       rate_switch,
    output logic       wdog_timeout
);

    localparam logic [1:0] NOM_IDLE  = 2'd0;
    localparam logic [1:0] NOM_FRAME = 2'd1;
    localparam logic [1:0] DATA      = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [14:0] nom_sh_q, dat_sh_q;
    logic [14:0] act_q;
    logic        data_phase_q, data_phase_d;
    logic        rate_switch_q, rate_switch_d;
    logic        wdog_timeout_q, wdog_timeout_d;
    logic        abort_ev;
    logic        shadow_load;
    logic        wdog_hit;

    assign abort_ev    = go_error_frame | go_overload_frame;
    assign shadow_load = (state_q == NOM_IDLE) | reset_mode;

`ifdef CAN_BRS_WATCHDOG_EN
    logic [WDOG_W-1:0] wdog_cnt_q, wdog_cnt_d;

    assign wdog_hit = (state_q == DATA) & sample_point
                    & (wdog_cnt_q >= WDOG_LIMIT - 1'b1);

    // Counter is held at zero outside DATA so it starts fresh on entry
    always_comb begin
        wdog_cnt_d = wdog_cnt_q;
        if (state_q != DATA)
            wdog_cnt_d = '0;
        else if (sample_point && wdog_cnt_q != {WDOG_W{1'b1}})
            wdog_cnt_d = wdog_cnt_q + 1'b1;
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wdog_cnt_q <= '0;
        else     wdog_cnt_q <= wdog_cnt_d;
    end
`else
    logic unused_wdog;
    assign unused_wdog = ^{WDOG_LIMIT, sample_point};
    assign wdog_hit    = 1'b0;
`endif

    // Next-state decode; reset_mode dominates, then error/overload
    always_comb begin
        state_d        = state_q;
        wdog_timeout_d = 1'b0;
        if (reset_mode) begin
            state_d = NOM_IDLE;
        end else begin
            case (state_q)
                NOM_IDLE: begin
                    if (!rx_idle) state_d = NOM_FRAME;
                end
                NOM_FRAME: begin
                    if (rx_idle)
                        state_d = NOM_IDLE;
                    else if (go_rx_brs_on && en_fd && !abort_ev)
                        state_d = DATA;
                end
                DATA: begin
                    if (abort_ev) begin
                        state_d = rx_idle ? NOM_IDLE : NOM_FRAME;
                    end else if (wdog_hit) begin
                        state_d        = NOM_FRAME;
                        wdog_timeout_d = 1'b1;
                    end else if (rx_idle) begin
                        state_d = NOM_IDLE;
                    end else if (go_rx_crc_lim) begin
                        state_d = NOM_FRAME;
                    end
                end
                default: state_d = NOM_IDLE;
            endcase
        end
    end

    // A back-to-back timing change still lands, but its strobe is dropped
    always_comb begin
        data_phase_d  = (state_d == DATA);
        rate_switch_d = (data_phase_d != data_phase_q) & ~rate_switch_q;
    end

    // State and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= NOM_IDLE;
            data_phase_q   <= 1'b0;
            rate_switch_q  <= 1'b0;
            wdog_timeout_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            data_phase_q   <= data_phase_d;
            rate_switch_q  <= rate_switch_d;
            wdog_timeout_q <= wdog_timeout_d;
        end
    end

    // Shadow timing sets track the register file only while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            nom_sh_q <= '0;
            dat_sh_q <= '0;
        end else if (shadow_load) begin
            nom_sh_q <= {nom_brp, nom_sjw, nom_tseg1, nom_tseg2};
            dat_sh_q <= {dat_brp, dat_sjw, dat_tseg1, dat_tseg2};
        end
    end

    // Registered timing mux toward the bit-timing logic
    always_ff @(posedge clk or posedge rst) begin
        if (rst) act_q <= '0;
        else     act_q <= data_phase_q ? dat_sh_q : nom_sh_q;
    end

    assign act_brp      = act_q[14:9];
    assign act_sjw      = act_q[8:7];
    assign act_tseg1    = act_q[6:3];
    assign act_tseg2    = act_q[2:0];
    assign data_phase   = data_phase_q;
    assign rate_switch  = rate_switch_q;
    assign wdog_timeout = wdog_timeout_q;

endmodule

// File: tb/tb_can_brs_ctrl.sv
// Directed, table-driven bench for can_brs_ctrl.
// Watchdog expectations follow `define CAN_BRS_WATCHDOG_EN.
module tb_can_brs_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       reset_mode, en_fd, rx_idle, sample_point;
    logic       go_rx_brs_on, go_rx_crc_lim, go_error_frame, go_overload_frame;
    logic [5:0] nom_brp, dat_brp;
    logic [1:0] nom_sjw, dat_sjw;
    logic [3:0] nom_tseg1, dat_tseg1;
    logic [2:0] nom_tseg2, dat_tseg2;
    logic [5:0] act_brp;
    logic [1:0] act_sjw;
    logic [3:0] act_tseg1;
    logic [2:0] act_tseg2;
    logic       data_phase, rate_switch, wdog_timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    can_brs_ctrl #(.WDOG_W(10), .WDOG_LIMIT(10'd8)) dut (
        .clk(clk), .rst(rst), .reset_mode(reset_mode), .en_fd(en_fd),
        .nom_brp(nom_brp), .nom_sjw(nom_sjw), .nom_tseg1(nom_tseg1),
        .nom_tseg2(nom_tseg2), .dat_brp(dat_brp), .dat_sjw(dat_sjw),
        .dat_tseg1(dat_tseg1), .dat_tseg2(dat_tseg2), .rx_idle(rx_idle),
        .sample_point(sample_point), .go_rx_brs_on(go_rx_brs_on),
        .go_rx_crc_lim(go_rx_crc_lim), .go_error_frame(go_error_frame),
        .go_overload_frame(go_overload_frame), .act_brp(act_brp),
        .act_sjw(act_sjw), .act_tseg1(act_tseg1), .act_tseg2(act_tseg2),
        .data_phase(data_phase), .rate_switch(rate_switch),
        .wdog_timeout(wdog_timeout)
    );

    // in = {reset_mode, en_fd, rx_idle, brs_on, crc_lim, error, overload}
    typedef struct {
        logic [6:0] in;
        logic       dp;
        logic       rs;
        logic [5:0] brp;
    } vec_t;

    vec_t tbl [32];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulses();
        go_rx_brs_on      = 1'b0;
        go_rx_crc_lim     = 1'b0;
        go_error_frame    = 1'b0;
        go_overload_frame = 1'b0;
        sample_point      = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{7'b0110000, 1'b0, 1'b0, 6'd9};
        tbl[1]  = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[2]  = '{7'b0001000, 1'b0, 1'b0, 6'd9};
        tbl[3]  = '{7'b0101010, 1'b0, 1'b0, 6'd9};
        tbl[4]  = '{7'b0100100, 1'b0, 1'b0, 6'd9};
        tbl[5]  = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[6]  = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[7]  = '{7'b0101000, 1'b1, 1'b0, 6'd1};
        tbl[8]  = '{7'b0100100, 1'b0, 1'b1, 6'd1};
        tbl[9]  = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[10] = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[11] = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[12] = '{7'b0100110, 1'b0, 1'b1, 6'd1};
        tbl[13] = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[14] = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[15] = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[16] = '{7'b0100001, 1'b0, 1'b1, 6'd1};
        tbl[17] = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[18] = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[19] = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[20] = '{7'b0110000, 1'b0, 1'b1, 6'd1};
        tbl[21] = '{7'b0110000, 1'b0, 1'b0, 6'd9};
        tbl[22] = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[23] = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[24] = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[25] = '{7'b1100000, 1'b0, 1'b1, 6'd1};
        tbl[26] = '{7'b1100000, 1'b0, 1'b0, 6'd9};
        tbl[27] = '{7'b0100000, 1'b0, 1'b0, 6'd9};
        tbl[28] = '{7'b0101000, 1'b1, 1'b1, 6'd9};
        tbl[29] = '{7'b0100000, 1'b1, 1'b0, 6'd1};
        tbl[30] = '{7'b0110010, 1'b0, 1'b1, 6'd1};
        tbl[31] = '{7'b0110000, 1'b0, 1'b0, 6'd9};

        rst        = 1'b1;
        reset_mode = 1'b0;
        en_fd      = 1'b1;
        rx_idle    = 1'b1;
        clr_pulses();
        nom_brp = 6'd9; nom_sjw = 2'd1; nom_tseg1 = 4'd5; nom_tseg2 = 3'd2;
        dat_brp = 6'd1; dat_sjw = 2'd3; dat_tseg1 = 4'd2; dat_tseg2 = 3'd1;

        // reset state
        #12;
        chk("rst_dp", {31'd0, data_phase}, 32'd0);
        chk("rst_rs", {31'd0, rate_switch}, 32'd0);
        chk("rst_wd", {31'd0, wdog_timeout}, 32'd0);
        chk("rst_brp", {26'd0, act_brp}, 32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        chk("init_brp", {26'd0, act_brp}, 32'd9);

        // per-cycle protocol table
        for (int i = 0; i < 32; i++) begin
            {reset_mode, en_fd, rx_idle, go_rx_brs_on, go_rx_crc_lim,
             go_error_frame, go_overload_frame} = tbl[i].in;
            step();
            chk($sformatf("tbl%0d_dp", i), {31'd0, data_phase}, {31'd0, tbl[i].dp});
            chk($sformatf("tbl%0d_rs", i), {31'd0, rate_switch}, {31'd0, tbl[i].rs});
            chk($sformatf("tbl%0d_brp", i), {26'd0, act_brp}, {26'd0, tbl[i].brp});
            chk($sformatf("tbl%0d_wd", i), {31'd0, wdog_timeout}, 32'd0);
        end
        clr_pulses();
        reset_mode = 1'b0;
        en_fd      = 1'b1;

        // shadow freeze during a frame
        chk("frz_pre", {28'd0, act_tseg1}, 32'd5);
        rx_idle = 1'b0;
        step();
        nom_tseg1 = 4'd8;
        step();
        step();
        chk("frz_hold", {28'd0, act_tseg1}, 32'd5);
        rx_idle = 1'b1;
        step();
        chk("frz_idle1", {28'd0, act_tseg1}, 32'd5);
        step();
        chk("frz_idle2", {28'd0, act_tseg1}, 32'd5);
        step();
        chk("frz_new", {28'd0, act_tseg1}, 32'd8);

        // watchdog in the data phase
        rx_idle = 1'b0;
        step();
        go_rx_brs_on = 1'b1;
        step();
        go_rx_brs_on = 1'b0;
        chk("wd_entry_dp", {31'd0, data_phase}, 32'd1);
        step();
        chk("wd_dat_sjw", {30'd0, act_sjw}, 32'd3);
        chk("wd_dat_tseg1", {28'd0, act_tseg1}, 32'd2);
        chk("wd_dat_tseg2", {29'd0, act_tseg2}, 32'd1);
        for (int i = 1; i <= 8; i++) begin
            sample_point = 1'b1;
            step();
            sample_point = 1'b0;
`ifdef CAN_BRS_WATCHDOG_EN
            if (i == 8) begin
                chk("wd_fire_dp", {31'd0, data_phase}, 32'd0);
                chk("wd_fire_rs", {31'd0, rate_switch}, 32'd1);
                chk("wd_fire_wd", {31'd0, wdog_timeout}, 32'd1);
            end else begin
                chk($sformatf("wd_sp%0d_dp", i), {31'd0, data_phase}, 32'd1);
                chk($sformatf("wd_sp%0d_wd", i), {31'd0, wdog_timeout}, 32'd0);
            end
`else
            chk($sformatf("wd_sp%0d_dp", i), {31'd0, data_phase}, 32'd1);
            chk($sformatf("wd_sp%0d_wd", i), {31'd0, wdog_timeout}, 32'd0);
`endif
        end
        step();
        chk("wd_after_wd", {31'd0, wdog_timeout}, 32'd0);
        chk("wd_after_rs", {31'd0, rate_switch}, 32'd0);
`ifndef CAN_BRS_WATCHDOG_EN
        go_rx_crc_lim = 1'b1;
        step();
        go_rx_crc_lim = 1'b0;
        chk("wd_exit_dp", {31'd0, data_phase}, 32'd0);
`endif
        step();

        // asynchronous reset in the middle of the data phase
        go_rx_brs_on = 1'b1;
        step();
        go_rx_brs_on = 1'b0;
        step();
        chk("arst_pre_dp", {31'd0, data_phase}, 32'd1);
        chk("arst_pre_brp", {26'd0, act_brp}, 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_dp", {31'd0, data_phase}, 32'd0);
        chk("arst_brp", {26'd0, act_brp}, 32'd0);
        chk("arst_rs", {31'd0, rate_switch}, 32'd0);
        step();
        chk("arst_hold_dp", {31'd0, data_phase}, 32'd0);
        rst     = 1'b0;
        rx_idle = 1'b1;
        step();
        step();
        chk("arst_rel_brp", {26'd0, act_brp}, 32'd9);
        chk("arst_rel_rs", {31'd0, rate_switch}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
